// File: rtl/risc_v_mike_uart_mmio_if.sv
// Data-memory bus between the core and the UART MMIO bridge.
//   bus_addr    : byte address (ALU result)
//   bus_write   : store strobe, one cycle per store
//   bus_read    : load strobe, one cycle per load
//   bus_wr_data : store data
//   bus_rd_data : load data from the bridge (combinational from bus_addr)
//   bus_hit     : address falls in the bridge's register window
// master = core side, slave = bridge side.
interface risc_v_mike_uart_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_hit;

  modport master (
    output bus_addr,
    output bus_write,
    output bus_read,
    output bus_wr_data,
    input  bus_rd_data,
    input  bus_hit
  );

  modport slave (
    input  bus_addr,
    input  bus_write,
    input  bus_read,
    input  bus_wr_data,
    output bus_rd_data,
    output bus_hit
  );
endinterface

// File: rtl/risc_v_mike_uart_mmio.sv
// Memory-mapped bridge between the core data bus and the UART flag/strobe interface.
// A TX FIFO is drained by a send FSM; an RX FIFO is filled by a capture FSM.
//
// Register window at BASE_ADDR (offset = bus_addr[3:0]):
//   0x0 TXDATA (W)  push a character
//   0x4 RXDATA (R)  FIFO head, zero-extended; bus_read pops
//   0x8 STATUS (R)  {tx_overflow, tx_busy, rx_overrun, rx_full, rx_empty, tx_empty, tx_full}
//   0xC CTRL   (W)  bit0 clear sticky bits, bit1 flush both FIFOs (self-clearing)
//
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   bus             : data-memory bus (slave modport)
//   tx_data/tx_send : character and one-cycle start pulse to the UART
//   tx_flag/_clr    : UART transmit-done flag and its one-cycle clear
//   rx_data/rx_flag : received character and receive-valid flag
//   rx_flag_clr     : one-cycle clear of rx_flag
//
// Optional feature, macro RISC_V_MIKE_UART_MMIO_IRQ_EN:
//   adds output irq and an IRQ_EN register (bits [2:0]) at BASE_ADDR + 0x10, which sits in
//   the next 16-byte window, so bus_hit is widened to cover it in that build.
module risc_v_mike_uart_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  risc_v_mike_uart_mmio_if.slave bus,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_send,
  input  logic                tx_flag,
  output logic                tx_flag_clr,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_flag,
  output logic                rx_flag_clr
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {TxIdle, TxSend, TxWait, TxClr} tx_state_e;
  typedef enum logic [0:0] {RxIdle, RxClr} rx_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       win_hit;
  logic [3:0] off;
  logic       wr_tx, wr_ctrl, rd_pop_req;
  logic       clr_sticky, flush;

  assign win_hit    = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off        = bus.bus_addr[3:0];
  assign wr_tx      = bus.bus_write && win_hit && (off == 4'h0);
  assign wr_ctrl    = bus.bus_write && win_hit && (off == 4'hC);
  assign rd_pop_req = bus.bus_read && win_hit && (off == 4'h4);
  assign clr_sticky = wr_ctrl && bus.bus_wr_data[0];
  assign flush      = wr_ctrl && bus.bus_wr_data[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic              tx_overflow_q, tx_overflow_d;
  logic              rx_overrun_q, rx_overrun_d;
  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_send_q, tx_send_d;
  logic              tx_clr_q, tx_clr_d;
  logic              rx_clr_q, rx_clr_d;

  // ---------------------------------------------------------------------------
  // FIFO flags (MSB compare on AW+1 bit pointers)
  // ---------------------------------------------------------------------------
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign tx_busy  = (tx_state_q != TxIdle);

  logic [DATA_W-1:0] tx_head, rx_head;
  assign tx_head = tx_mem_q[tx_rptr_q[AW-1:0]];
  assign rx_head = rx_mem_q[rx_rptr_q[AW-1:0]];

  // Full is judged on the current state, so a same-cycle pop never makes room.
  // Flush wins over everything, including the TX FSM's pop.
  logic tx_push, tx_pop, rx_push_req, rx_push, rx_pop;

  assign tx_pop      = (tx_state_q == TxIdle) && !tx_empty && !flush;
  assign tx_push     = wr_tx && !tx_full && !flush;
  assign rx_push_req = (rx_state_q == RxIdle) && rx_flag;
  assign rx_push     = rx_push_req && !rx_full && !flush;
  assign rx_pop      = rd_pop_req && !rx_empty && !flush;

  always_comb begin
    tx_wptr_d = tx_wptr_q + PW'(tx_push);
    tx_rptr_d = tx_rptr_q + PW'(tx_pop);
    rx_wptr_d = rx_wptr_q + PW'(rx_push);
    rx_rptr_d = rx_rptr_q + PW'(rx_pop);
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
    end
  end

  // A new error event in the same cycle as a clear is kept.
  always_comb begin
    tx_overflow_d = (clr_sticky ? 1'b0 : tx_overflow_q) | (wr_tx && tx_full && !flush);
    rx_overrun_d  = (clr_sticky ? 1'b0 : rx_overrun_q) | (rx_push_req && rx_full && !flush);
  end

  // ---------------------------------------------------------------------------
  // TX FSM: pop -> pulse tx_send -> wait for tx_flag -> clear it
  // ---------------------------------------------------------------------------
  // In Clr, the cycle after a clear pulse is spent letting the UART drop its flag; if the
  // flag is still up after that the clear is pulsed again.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_send_d  = 1'b0;
    tx_clr_d   = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (tx_pop) begin
          tx_data_d  = tx_head;
          tx_send_d  = 1'b1;
          tx_state_d = TxSend;
        end
      end
      TxSend: tx_state_d = TxWait;
      TxWait: begin
        if (tx_flag) begin
          tx_clr_d   = 1'b1;
          tx_state_d = TxClr;
        end
      end
      TxClr: begin
        if (!tx_clr_q) begin
          if (tx_flag) tx_clr_d = 1'b1;
          else         tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FSM: capture once on rx_flag, then clear until the flag drops
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clr_d   = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_flag) begin
          rx_clr_d   = 1'b1;
          rx_state_d = RxClr;
        end
      end
      RxClr: begin
        if (!rx_clr_q) begin
          if (rx_flag) rx_clr_d = 1'b1;
          else         rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional interrupt
  // ---------------------------------------------------------------------------
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
  logic       irq_hit;
  logic [2:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  assign irq_hit = (bus.bus_addr[31:4] == BASE_ADDR[31:4] + 28'd1) &&
                   (bus.bus_addr[3:0] == 4'h0);

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus.bus_write && irq_hit) irq_en_d = bus.bus_wr_data[2:0];
    irq_d = (irq_en_q[0] && !rx_empty) ||
            (irq_en_q[1] && tx_empty && !tx_busy) ||
            (irq_en_q[2] && (rx_overrun_q || tx_overflow_q));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq         = irq_q;
  assign bus.bus_hit = win_hit || irq_hit;
`else
  assign bus.bus_hit = win_hit;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status;
  assign status = {25'd0, tx_overflow_q, tx_busy, rx_overrun_q, rx_full, rx_empty,
                   tx_empty, tx_full};

  always_comb begin
    bus.bus_rd_data = '0;
    if (win_hit) begin
      case (off)
        4'h4:    bus.bus_rd_data = rx_empty ? 32'd0 : 32'(rx_head);
        4'h8:    bus.bus_rd_data = status;
        default: bus.bus_rd_data = '0;
      endcase
    end
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
    if (irq_hit) bus.bus_rd_data = {29'd0, irq_en_q};
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_mem_q      <= '{default: '0};
      rx_mem_q      <= '{default: '0};
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      tx_overflow_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_state_q    <= TxIdle;
      rx_state_q    <= RxIdle;
      tx_data_q     <= '0;
      tx_send_q     <= 1'b0;
      tx_clr_q      <= 1'b0;
      rx_clr_q      <= 1'b0;
    end else begin
      if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.bus_wr_data[DATA_W-1:0];
      if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_data;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      tx_overflow_q <= tx_overflow_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      tx_clr_q      <= tx_clr_d;
      rx_clr_q      <= rx_clr_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign tx_flag_clr = tx_clr_q;
  assign rx_flag_clr = rx_clr_q;

  // Upper store-data bits and bus_read outside RXDATA carry no meaning here.
  logic unused_bus;
  assign unused_bus = ^{bus.bus_wr_data[31:DATA_W]};

endmodule

// File: tb/tb_risc_v_mike_uart_mmio.sv
`timescale 1ns/1ps
module tb_risc_v_mike_uart_mmio;
  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int          Depth = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_send, tx_flag, tx_flag_clr;
  logic [7:0] rx_data;
  logic       rx_flag, rx_flag_clr;
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  risc_v_mike_uart_mmio_if bus_if ();

  risc_v_mike_uart_mmio #(
    .BASE_ADDR (Base),
    .FIFO_DEPTH(Depth),
    .DATA_W    (8)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus_if.slave),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_flag    (tx_flag),
    .tx_flag_clr(tx_flag_clr),
    .rx_data    (rx_data),
    .rx_flag    (rx_flag),
    .rx_flag_clr(rx_flag_clr)
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // ---------------------------------------------------------------------------
  // UART model: raises tx_flag 20 cycles after tx_send (when tx_auto), delivers
  // queued RX bytes one at a time, drops each flag when its clear is seen.
  // ---------------------------------------------------------------------------
  bit         tx_auto;
  int         tx_cnt;
  int         n_send, n_tx_clr, n_rx_clr;
  logic [7:0] sent_q[$];
  logic [7:0] rx_req[256];
  int         rx_n, rx_idx;

  initial begin
    n_send = 0; n_tx_clr = 0; n_rx_clr = 0; rx_idx = 0; tx_cnt = 0; rx_data = '0;
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_flag <= 1'b0;
      rx_flag <= 1'b0;
      tx_cnt  <= 0;
    end else begin
      if (tx_send) begin
        sent_q.push_back(tx_data);
        n_send <= n_send + 1;
      end
      if (tx_send && tx_auto) tx_cnt <= 20;
      else if (tx_cnt > 0) begin
        tx_cnt <= tx_cnt - 1;
        if (tx_cnt == 1) tx_flag <= 1'b1;
      end
      if (tx_flag_clr) begin
        tx_flag  <= 1'b0;
        n_tx_clr <= n_tx_clr + 1;
      end
      if (rx_flag_clr) begin
        rx_flag  <= 1'b0;
        n_rx_clr <= n_rx_clr + 1;
      end else if (!rx_flag && rx_idx < rx_n) begin
        rx_data <= rx_req[rx_idx];
        rx_idx  <= rx_idx + 1;
        rx_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_cmp, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
    bus_if.bus_addr    = Base + off;
    bus_if.bus_wr_data = d;
    bus_if.bus_write   = 1'b1;
    @(negedge clk);
    bus_if.bus_write   = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] off, input logic pop, output logic [31:0] d);
    bus_if.bus_addr = Base + off;
    bus_if.bus_read = pop;
    #1 d = bus_if.bus_rd_data;
    @(negedge clk);
    bus_if.bus_read = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(32'h8, 1'b0, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic deliver(input logic [7:0] b);
    rx_req[rx_n] = b;
    rx_n++;
  endtask

  task automatic wait_rx_done(input string name);
    int k;
    k = 0;
    while (!(rx_idx == rx_n && !rx_flag && !rx_flag_clr) && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(name, k < 400, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Register-decode vectors after reset
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] d;
  logic [7:0]  rq[$];
  logic        ovr;
  int          s0, c0, n0, k;
  logic [31:0] exp_st;

  initial begin
    bus_if.bus_addr = '0; bus_if.bus_write = 1'b0; bus_if.bus_read = 1'b0;
    bus_if.bus_wr_data = '0;
    tx_auto = 1'b0; rx_n = 0; n_cmp = 0; n_bad = 0;
    n_rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{"rd_txdata",   Base + 32'h0, 1'b1, 32'h0};
    vecs[1] = '{"rd_rxdata",   Base + 32'h4, 1'b1, 32'h0};
    vecs[2] = '{"rd_status",   Base + 32'h8, 1'b1, 32'h6};
    vecs[3] = '{"rd_ctrl",     Base + 32'hC, 1'b1, 32'h0};
    vecs[4] = '{"rd_unmap2",   Base + 32'h2, 1'b1, 32'h0};
    vecs[5] = '{"rd_unmapF",   Base + 32'hF, 1'b1, 32'h0};
    vecs[6] = '{"rd_below",    Base - 32'h4, 1'b0, 32'h0};
`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
    vecs[7] = '{"rd_irq_en",   Base + 32'h10, 1'b1, 32'h0};
`else
    vecs[7] = '{"rd_off10",    Base + 32'h10, 1'b0, 32'h0};
`endif
    vecs[8] = '{"rd_alias",    32'h8000_1008, 1'b0, 32'h0};

    // Reset state
    do_reset();
    check("rst_tx_send", tx_send, 1'b0);
    check("rst_tx_flag_clr", tx_flag_clr, 1'b0);
    check("rst_rx_flag_clr", rx_flag_clr, 1'b0);
    check("rst_tx_data", tx_data, 8'h0);
    for (int i = 0; i < 9; i++) begin
      bus_if.bus_addr = vecs[i].addr;
      #1;
      check({vecs[i].name, "_hit"}, bus_if.bus_hit, vecs[i].hit);
      check({vecs[i].name, "_data"}, bus_if.bus_rd_data, vecs[i].rd);
      @(negedge clk);
    end
    // Writes to unmapped offsets leave the status untouched
    bus_wr(32'h4, 32'hFF);
    bus_wr(32'h8, 32'hFF);
    check_status("unmapped_wr_status", 32'h06);

    // TX: two characters with a UART answering after 20 cycles
    tx_auto = 1'b1;
    s0 = sent_q.size(); c0 = n_tx_clr; n0 = n_send;
    bus_wr(32'h0, 32'h41);
    check("tx_send_not_early", tx_send, 1'b0);
    @(negedge clk);
    check("tx_send_latency", tx_send, 1'b1);
    check("tx_data_first", tx_data, 8'h41);
    bus_wr(32'h0, 32'h42);
    check("tx_send_one_cycle", tx_send, 1'b0);
    k = 0;
    while (!(n_tx_clr == c0 + 2 && !tx_flag) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("tx_done_timeout", k < 400, 1'b1);
    repeat (3) @(negedge clk);
    check("tx_count", sent_q.size() - s0, 2);
    if (sent_q.size() >= s0 + 2) begin
      check("tx_char0", sent_q[s0], 8'h41);
      check("tx_char1", sent_q[s0+1], 8'h42);
    end
    check("tx_send_pulses", n_send - n0, 2);
    check("tx_clr_pulses", n_tx_clr - c0, 2);
    check("tx_data_hold", tx_data, 8'h42);
    check_status("tx_end_status", 32'h06);
    tx_auto = 1'b0;

    // TX overflow: UART never answers
    do_reset();
    n0 = n_send;
    for (int i = 0; i < 9; i++) begin
      bus_if.bus_addr = Base; bus_if.bus_wr_data = 32'h10 + i; bus_if.bus_write = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_write = 1'b0;
    check_status("ovf_nine_status", 32'h25);
    check("ovf_tx_data", tx_data, 8'h10);
    bus_wr(32'h0, 32'h99);
    check_status("ovf_tenth_status", 32'h65);
    check("ovf_one_send", n_send - n0, 1);
    bus_wr(32'hC, 32'h1);
    check_status("ctrl_clear_status", 32'h25);
    bus_wr(32'hC, 32'h2);
    check_status("ctrl_flush_status", 32'h26);
    check("flush_keeps_tx_data", tx_data, 8'h10);
    for (int i = 0; i < 3; i++) bus_wr(32'h0, 32'h70 + i);
    check_status("queued3_status", 32'h24);

    // Reset during WAIT
    n_rst = 1'b0;
    #1;
    check("rst_mid_tx_send", tx_send, 1'b0);
    check("rst_mid_tx_flag_clr", tx_flag_clr, 1'b0);
    check("rst_mid_rx_flag_clr", rx_flag_clr, 1'b0);
    check("rst_mid_tx_data", tx_data, 8'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_status("rst_mid_status", 32'h06);
    repeat (5) @(negedge clk);
    check("rst_no_resend", n_send - n0, 1);

    // RX: two characters
    c0 = n_rx_clr;
    deliver(8'h55);
    deliver(8'hAA);
    wait_rx_done("rx2_timeout");
    check("rx2_clr_pulses", n_rx_clr - c0, 2);
    check_status("rx2_status", 32'h02);
    bus_rd(32'h4, 1'b1, d); check("rx2_read0", d, 32'h55);
    bus_rd(32'h4, 1'b1, d); check("rx2_read1", d, 32'hAA);
    bus_rd(32'h4, 1'b1, d); check("rx2_read_empty", d, 32'h0);
    check_status("rx2_end_status", 32'h06);

    // RX overrun
    for (int i = 0; i < 9; i++) deliver(8'h60 + 8'(i));
    wait_rx_done("rx9_timeout");
    check_status("rx9_status", 32'h1A);
    for (int i = 0; i < 8; i++) begin
      bus_rd(32'h4, 1'b1, d);
      check($sformatf("rx9_read%0d", i), d, 32'h60 + i);
    end
    check_status("rx9_drained_status", 32'h16);
    bus_wr(32'hC, 32'h1);
    check_status("rx9_cleared_status", 32'h06);

    // Randomized RX traffic against a queue model
    rq.delete();
    ovr = 1'b0;
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        logic [7:0] b;
        b = 8'($urandom);
        deliver(b);
        wait_rx_done("rand_rx_timeout");
        if (rq.size() < Depth) rq.push_back(b);
        else ovr = 1'b1;
      end else if (op <= 6) begin
        bus_rd(32'h4, 1'b1, d);
        check($sformatf("rand_read_%0d", it), d, (rq.size() != 0) ? 32'(rq[0]) : 32'h0);
        if (rq.size() != 0) void'(rq.pop_front());
      end else if (op == 8) begin
        bus_wr(32'hC, 32'h1);
        ovr = 1'b0;
      end else if (op == 9 && ($urandom_range(0, 3) == 0)) begin
        bus_wr(32'hC, 32'h2);
        rq.delete();
      end else begin
        exp_st = 32'h2 | ((rq.size() == 0) ? 32'h4 : 32'h0) |
                 ((rq.size() == Depth) ? 32'h8 : 32'h0) | (ovr ? 32'h10 : 32'h0);
        check_status($sformatf("rand_status_%0d", it), exp_st);
      end
    end

`ifdef RISC_V_MIKE_UART_MMIO_IRQ_EN
    do_reset();
    check("irq_reset", irq, 1'b0);
    bus_wr(32'h10, 32'h1);
    bus_rd(32'h10, 1'b0, d);
    check("irq_en_readback", d, 32'h1);
    check("irq_idle_rx_empty", irq, 1'b0);
    deliver(8'h33);
    wait_rx_done("irq_rx_timeout");
    check("irq_rx_pending", irq, 1'b1);
    bus_rd(32'h4, 1'b1, d);
    check("irq_pop_data", d, 32'h33);
    check("irq_lag", irq, 1'b1);
    @(negedge clk);
    check("irq_cleared", irq, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
